// File: rtl/reg64_bus_arbiter_pkg.sv
// reg_arb_pkg: shared FSM state type and default sizes for the register arbiter.
package reg_arb_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
    localparam int NUM_REQ_DEFAULT    = 4;
    localparam int DATA_WIDTH_DEFAULT = 64;
endpackage

// File: rtl/reg64_bus_arbiter_if.sv
// reg64_bus_arbiter_if: requester handshake and shared-register bus signals.
interface reg64_bus_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic [DATA_WIDTH-1:0]         reg_in_data;
    logic                          reg_input_enable;
    logic                          reg_output_enable;
    logic [DATA_WIDTH-1:0]         reg_out_data;
    logic                          busy;
    modport master (
        output req_valid, req_write, req_wdata, reg_out_data,
        input  req_ready, rsp_valid, rsp_rdata, reg_in_data, reg_input_enable, reg_output_enable, busy
    );
    modport slave (
        input  req_valid, req_write, req_wdata, reg_out_data,
        output req_ready, rsp_valid, rsp_rdata, reg_in_data, reg_input_enable, reg_output_enable, busy
    );
endinterface

// File: rtl/reg64_bus_arbiter_rr.sv
// rr_arbiter: picks the first active request at or after pointer, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      pointer,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IW-1:0]      grant_idx,
    output logic               any_grant
);
    logic [IW-1:0] idx;
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any_grant    = 1'b0;
        idx          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(pointer) + k) % NUM_REQ);
            if (!any_grant && req[idx]) begin
                any_grant         = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg64_bus_arbiter.sv
// reg64_bus_arbiter: round-robin access of NUM_REQ requesters to one shared register.
// Every control output is a flop loaded from the next state, so enables never glitch.
module reg64_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input logic               clock,
    input logic               clear_n,
    reg64_bus_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    sel_q, sel_d;
    logic [NUM_REQ-1:0]    ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic                  we_q, we_d, oe_q, oe_d, busy_q, busy_d;
    logic [DATA_WIDTH-1:0] in_data_q, in_data_d, rdata_q, rdata_d;
    logic [NUM_REQ-1:0]    g_onehot;
    logic [IW-1:0]         g_idx;
    logic                  g_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req          (bus.req_valid),
        .pointer      (ptr_q),
        .grant_onehot (g_onehot),
        .grant_idx    (g_idx),
        .any_grant    (g_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        in_data_d = in_data_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: if (g_any) begin
                state_d = bus.req_write[g_idx] ? WRITE : READ;
                ptr_d   = (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
                sel_d   = g_onehot;
                if (bus.req_write[g_idx])
                    in_data_d = bus.req_wdata[g_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            WRITE: state_d = IDLE;
            READ: begin
                state_d = RESP;
                rdata_d = bus.reg_out_data;
            end
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d     = (state_d == WRITE || state_d == READ) ? sel_d : '0;
        rsp_valid_d = (state_d == RESP) ? sel_d : '0;
        we_d        = state_d == WRITE;
        oe_d        = state_d == READ;
        busy_d      = state_d != IDLE;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            in_data_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            in_data_q   <= in_data_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.req_ready         = ready_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_rdata         = rdata_q;
    assign bus.reg_in_data       = in_data_q;
    assign bus.reg_input_enable  = we_q;
    assign bus.reg_output_enable = oe_q;
    assign bus.busy              = busy_q;
endmodule
